// File: rtl/rtc_trans_seq.sv
// Transaction sequencer feeding the RTC control-signal generator: command write, N_REGS reads, single writes.
// Optional watchdog on the WAIT state enabled by defining RTC_SEQ_TIMEOUT_EN.
module rtc_trans_seq #(
  parameter int unsigned N_REGS    = 6,
  parameter logic [7:0]  BASE_ADDR = 8'h21,
  parameter logic [7:0]  CMD_ADDR  = 8'hF0,
  parameter logic [7:0]  CMD_DATA  = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  wr_req,
  input  logic [7:0]            wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  flag_done,
  input  logic                  out_direccion_dato,
  input  logic                  rd_n,
  input  logic [7:0]            ad_in,
  output logic                  en_funcion,
  output logic                  in_escribir_leer,
  output logic [7:0]            ad_out,
  output logic                  ad_oe,
  output logic [8*N_REGS-1:0]   rd_regs,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  wr_ack,
  output logic                  err
);

  localparam int unsigned IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [1:0] K_CMD  = 2'd0;
  localparam logic [1:0] K_READ = 2'd1;
  localparam logic [1:0] K_WR   = 2'd2;

  logic [2:0]       r_state;
  logic [1:0]       r_kind;
  logic [IDX_W-1:0] r_idx;
  logic             r_pending;
  logic [7:0]       r_cur_addr;
  logic [7:0]       r_cur_data;
  logic             r_cur_dir;
  logic [7:0]       r_shadow;
  logic [7:0]       r_regs [N_REGS];
  logic             r_frame_done;
  logic             r_wr_ack;
  logic             w_sample;
  logic [7:0]       w_shadow_nxt;

`ifdef RTC_SEQ_TIMEOUT_EN
  logic [5:0]       r_wdog;
  logic             r_err;
`endif

  // The capture on flag_done must include a sample taken in that same cycle.
  assign w_sample     = (r_state == S_WAIT) && (r_kind == K_READ) && out_direccion_dato && !rd_n;
  assign w_shadow_nxt = w_sample ? ad_in : r_shadow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_kind       <= K_CMD;
      r_idx        <= '0;
      r_pending    <= 1'b0;
      r_cur_addr   <= '0;
      r_cur_data   <= '0;
      r_cur_dir    <= 1'b0;
      r_shadow     <= '0;
      r_frame_done <= 1'b0;
      r_wr_ack     <= 1'b0;
      for (int unsigned i = 0; i < N_REGS; i++) r_regs[i] <= '0;
`ifdef RTC_SEQ_TIMEOUT_EN
      r_wdog       <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      r_wr_ack     <= 1'b0;
      r_shadow     <= w_shadow_nxt;
      if (start && (r_state != S_IDLE)) r_pending <= 1'b1;
`ifdef RTC_SEQ_TIMEOUT_EN
      r_wdog <= (r_state == S_WAIT) ? r_wdog + 6'd1 : '0;
`endif
      case (r_state)
        S_IDLE: begin
          if (wr_req) begin
            r_kind     <= K_WR;
            r_cur_addr <= wr_addr;
            r_cur_data <= wr_data;
            r_cur_dir  <= 1'b1;
            r_state    <= S_LOAD;
            if (start) r_pending <= 1'b1;
          end else if (start || r_pending) begin
            r_kind     <= K_CMD;
            r_cur_addr <= CMD_ADDR;
            r_cur_data <= CMD_DATA;
            r_cur_dir  <= 1'b1;
            r_idx      <= '0;
            r_pending  <= 1'b0;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD:  r_state <= S_ISSUE;
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (flag_done) begin
            if (r_kind == K_READ) r_regs[r_idx] <= w_shadow_nxt;
            r_state <= S_GAP;
          end
`ifdef RTC_SEQ_TIMEOUT_EN
          else if (r_wdog == 6'd39) begin
            r_err     <= 1'b1;
            r_pending <= 1'b0;
            r_state   <= S_IDLE;
          end
`endif
        end
        S_GAP: begin
          case (r_kind)
            K_CMD: begin
              r_kind     <= K_READ;
              r_idx      <= '0;
              r_cur_addr <= BASE_ADDR;
              r_cur_data <= '0;
              r_cur_dir  <= 1'b0;
              r_state    <= S_LOAD;
            end
            K_READ: begin
              if (r_idx == IDX_W'(N_REGS - 1)) begin
                r_frame_done <= 1'b1;
                r_state      <= S_IDLE;
              end else begin
                r_idx      <= r_idx + IDX_W'(1);
                r_cur_addr <= BASE_ADDR + 8'(r_idx) + 8'd1;
                r_state    <= S_LOAD;
              end
            end
            default: begin
              r_wr_ack <= 1'b1;
              r_state  <= S_IDLE;
            end
          endcase
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ad_out = '0;
    ad_oe  = 1'b0;
    if (r_state != S_IDLE) begin
      if (!out_direccion_dato) begin
        ad_out = r_cur_addr;
        ad_oe  = 1'b1;
      end else if (r_cur_dir) begin
        ad_out = r_cur_data;
        ad_oe  = 1'b1;
      end
    end
  end

  always_comb begin
    rd_regs = '0;
    for (int unsigned i = 0; i < N_REGS; i++) rd_regs[i*8 +: 8] = r_regs[i];
  end

  assign en_funcion       = (r_state == S_ISSUE);
  assign in_escribir_leer = (r_state != S_IDLE) && r_cur_dir;
  assign busy             = (r_state != S_IDLE);
  assign frame_done       = r_frame_done;
  assign wr_ack           = r_wr_ack;
`ifdef RTC_SEQ_TIMEOUT_EN
  assign err              = r_err;
`else
  assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_trans_seq.sv
// Directed bench for rtc_trans_seq with a behavioural control-signal generator and RTC read-data model.
module tb_rtc_trans_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, wr_req;
  logic [7:0]  wr_addr, wr_data;
  logic        flag_done, out_direccion_dato, rd_n;
  logic [7:0]  ad_in;
  logic        en_funcion, in_escribir_leer, ad_oe, busy, frame_done, wr_ack, err;
  logic [7:0]  ad_out;
  logic [47:0] rd_regs;

  always #5 clk = ~clk;

  rtc_trans_seq #(.N_REGS(6), .BASE_ADDR(8'h21), .CMD_ADDR(8'hF0), .CMD_DATA(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_done(flag_done), .out_direccion_dato(out_direccion_dato), .rd_n(rd_n), .ad_in(ad_in),
    .en_funcion(en_funcion), .in_escribir_leer(in_escribir_leer), .ad_out(ad_out), .ad_oe(ad_oe),
    .rd_regs(rd_regs), .busy(busy), .frame_done(frame_done), .wr_ack(wr_ack), .err(err)
  );

  // Generator model: 24-count transaction, address phase below 12, RD low on counts 16..20 of reads.
  logic [4:0] gcnt;
  logic [7:0] m_addr;
  logic       blk = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      gcnt   <= '0;
      m_addr <= '0;
    end else begin
      if (en_funcion)        gcnt <= 5'd1;
      else if (gcnt == 5'd24) gcnt <= '0;
      else if (gcnt != 5'd0)  gcnt <= gcnt + 5'd1;
      if (gcnt == 5'd1) m_addr <= ad_out;
    end
  end

  assign flag_done          = (gcnt == 5'd24) && !blk;
  assign out_direccion_dato = (gcnt >= 5'd12);
  assign rd_n               = !((gcnt >= 5'd16) && (gcnt <= 5'd20) && !in_escribir_leer);
  assign ad_in              = m_addr - 8'h11;

  // Bus monitor
  int          en_cnt = 0, fd_cnt = 0, wa_cnt = 0, bad_rd = 0, bad_wr = 0, fd_busy = 0, lg_n = 0;
  logic [7:0]  mon_addr, mon_data;
  logic [16:0] lg [32];

  always @(negedge clk) begin
    if (reset) begin
      if (en_funcion) en_cnt++;
      if (frame_done) fd_cnt++;
      if (wr_ack) wa_cnt++;
      if (frame_done && busy) fd_busy++;
      if (gcnt == 5'd2) mon_addr = ad_out;
      if (gcnt == 5'd13) mon_data = ad_out;
      if (busy && out_direccion_dato && !in_escribir_leer && (ad_oe || ad_out != 8'h00)) bad_rd++;
      if (busy && out_direccion_dato && in_escribir_leer && !ad_oe) bad_wr++;
      if (flag_done && lg_n < 32) begin
        lg[lg_n] = {in_escribir_leer, mon_addr, in_escribir_leer ? mon_data : 8'h00};
        lg_n++;
      end
    end
  end

  int ntests = 0, nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_fd(input int target, input string tag);
    int k = 0;
    while (fd_cnt < target && k < 3000) begin @(posedge clk); k++; end
    chk(tag, 64'(fd_cnt >= target), 64'd1);
  endtask

  task automatic wait_wa(input int target, input string tag);
    int k = 0;
    while (wa_cnt < target && k < 3000) begin @(posedge clk); k++; end
    chk(tag, 64'(wa_cnt >= target), 64'd1);
  endtask

  int e0, f0, w0, l0, k;

  initial begin
    reset = 1'b0; start = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset held with start asserted
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {en_funcion, busy, ad_oe, in_escribir_leer, frame_done, wr_ack, err, ad_out}, 64'd0);
    chk("rst_regs", rd_regs, 64'd0);
    @(negedge clk) start = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_busy", busy, 64'd0);
    chk("idle_en", en_cnt, 64'd0);

    // Basic frame
    e0 = en_cnt; f0 = fd_cnt; l0 = lg_n;
    pulse_start();
    wait_fd(f0 + 1, "frame1_done");
    repeat (30) @(posedge clk);
    #1;
    chk("frame1_en", en_cnt - e0, 64'd7);
    chk("frame1_fd", fd_cnt - f0, 64'd1);
    chk("frame1_regs", rd_regs, 64'h151413121110);
    chk("frame1_cmd", lg[l0], {1'b1, 8'hF0, 8'h00});
    for (int i = 0; i < 6; i++) chk("frame1_raddr", lg[l0 + 1 + i], {1'b0, 8'h21 + 8'(i), 8'h00});
    chk("frame1_busy", busy, 64'd0);

    // Write and start in the same cycle
    e0 = en_cnt; f0 = fd_cnt; w0 = wa_cnt; l0 = lg_n;
    @(negedge clk) begin wr_req = 1'b1; wr_addr = 8'h22; wr_data = 8'h59; start = 1'b1; end
    @(negedge clk) begin wr_req = 1'b0; start = 1'b0; end
    wait_wa(w0 + 1, "coll_wack");
    chk("coll_order", fd_cnt - f0, 64'd0);
    wait_fd(f0 + 1, "coll_done");
    repeat (30) @(posedge clk);
    #1;
    chk("coll_wlog", lg[l0], {1'b1, 8'h22, 8'h59});
    chk("coll_cmdlog", lg[l0 + 1], {1'b1, 8'hF0, 8'h00});
    chk("coll_en", en_cnt - e0, 64'd8);
    chk("coll_wa", wa_cnt - w0, 64'd1);
    chk("coll_fd", fd_cnt - f0, 64'd1);
    chk("wr_oe", bad_wr, 64'd0);
    chk("rd_oe", bad_rd, 64'd0);

    // Repeated starts while busy collapse to one extra frame
    e0 = en_cnt; f0 = fd_cnt;
    pulse_start();
    repeat (60) @(posedge clk);
    pulse_start();
    @(negedge clk);
    pulse_start();
    @(negedge clk);
    pulse_start();
    wait_fd(f0 + 2, "multi_done");
    repeat (250) @(posedge clk);
    #1;
    chk("multi_fd", fd_cnt - f0, 64'd2);
    chk("multi_en", en_cnt - e0, 64'd14);
    chk("multi_busy", busy, 64'd0);
    chk("fd_busy_low", fd_busy, 64'd0);

    // Reset during third read data phase
    e0 = en_cnt; f0 = fd_cnt;
    pulse_start();
    k = 0;
    while (!(en_cnt == e0 + 4 && gcnt >= 5'd16) && k < 3000) begin @(negedge clk); k++; end
    chk("mid_reached", 64'(en_cnt == e0 + 4 && gcnt >= 5'd16), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_outs", {en_funcion, busy, ad_oe, in_escribir_leer, frame_done, wr_ack, err, ad_out}, 64'd0);
    chk("mid_regs", rd_regs, 64'd0);
    @(negedge clk) reset = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    chk("mid_nofd", fd_cnt - f0, 64'd0);
    chk("mid_busy", busy, 64'd0);
    chk("mid_regs2", rd_regs, 64'd0);

    // Generator never reports completion
    e0 = en_cnt;
    blk = 1'b1;
    pulse_start();
    repeat (150) @(posedge clk);
    #1;
    chk("to_en", en_cnt - e0, 64'd1);
`ifdef RTC_SEQ_TIMEOUT_EN
    chk("to_err", err, 64'd1);
    chk("to_busy", busy, 64'd0);
`else
    chk("to_err", err, 64'd0);
    chk("to_busy", busy, 64'd1);
`endif
    @(negedge clk) reset = 1'b0;
    blk = 1'b0;
    #1;
    chk("to_rst_err", err, 64'd0);
    @(negedge clk) reset = 1'b1;
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
